// File: rtl/axi4_lite_if.sv
// AXI4-Lite register-access interface; DUT side uses the slave modport.
interface axi4_lite_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/cci_sccb_master.sv
// SCCB/I2C master: one AXI4-Lite access becomes one 16-bit-address CCI
// register transaction on open-drain SCL/SDA, answered with ACK status.
module cci_sccb_master #(
    parameter int unsigned CLK_FREQ = 74_250_000,
    parameter int unsigned I2C_FREQ = 400_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    axi4_lite_if.slave axil_i,
    input  logic [6:0] slave_addr_i,
    input  logic       sda_i,
    output logic       scl_oe_o,
    output logic       sda_oe_o,
    output logic       busy_o
);
    localparam int unsigned QTR  = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned QW   = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [QW-1:0] QMAX = QW'(QTR - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEV_W, S_REG_HI, S_REG_LO, S_DATA_WR,
        S_RSTART, S_DEV_R, S_DATA_RD, S_STOP, S_TBUF, S_RESP
    } state_t;

    state_t        r_state;
    logic [QW-1:0] r_qcnt;
    logic [1:0]    r_phase;
    logic [3:0]    r_bit;
    logic [15:0]   r_addr;
    logic [7:0]    r_data;
    logic [6:0]    r_dev;
    logic          r_wr, r_err;
    logic [7:0]    r_rx;
    logic          r_scl_oe, r_sda_oe, r_busy;
    logic          r_awready, r_arready;
    logic          r_bvalid, r_rvalid;
    logic [1:0]    r_bresp, r_rresp;
    logic [7:0]    r_rdata;

    logic       w_qend, w_bend, w_tx_state, w_wr_req, w_rd_req, w_resp_done;
    logic [1:0] w_nphase;
    logic [3:0] w_nbit;
    state_t     w_nstate;
    logic [7:0] w_byte;
    logic       w_scl, w_sda;

    assign w_qend      = (r_qcnt == QMAX);
    assign w_bend      = w_qend && (r_phase == 2'd3);
    assign w_nphase    = r_phase + 2'd1;
    assign w_wr_req    = axil_i.awvalid && axil_i.wvalid;
    assign w_rd_req    = axil_i.arvalid;
    assign w_resp_done = (r_bvalid && axil_i.bready) || (r_rvalid && axil_i.rready);
    assign w_tx_state  = (r_state == S_DEV_W) || (r_state == S_REG_HI) || (r_state == S_REG_LO)
                      || (r_state == S_DATA_WR) || (r_state == S_DEV_R);

    // Sequencing at bit boundaries; a NACK on any transmitted byte diverts to STOP.
    always_comb begin
        w_nstate = r_state;
        w_nbit   = r_bit;
        if (w_bend) begin
            case (r_state)
                S_START:  begin w_nstate = S_DEV_W; w_nbit = 4'd0; end
                S_RSTART: begin w_nstate = S_DEV_R; w_nbit = 4'd0; end
                S_STOP:   w_nstate = S_TBUF;
                S_TBUF:   w_nstate = S_RESP;
                S_DEV_W, S_REG_HI, S_REG_LO, S_DATA_WR, S_DEV_R, S_DATA_RD: begin
                    if (r_bit != 4'd8) begin
                        w_nbit = r_bit + 4'd1;
                    end else begin
                        w_nbit = 4'd0;
                        if (r_err || r_state == S_DATA_WR || r_state == S_DATA_RD)
                            w_nstate = S_STOP;
                        else if (r_state == S_DEV_W)
                            w_nstate = S_REG_HI;
                        else if (r_state == S_REG_HI)
                            w_nstate = S_REG_LO;
                        else if (r_state == S_REG_LO)
                            w_nstate = r_wr ? S_DATA_WR : S_RSTART;
                        else
                            w_nstate = S_DATA_RD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (w_nstate)
            S_DEV_W:   w_byte = {r_dev, 1'b0};
            S_DEV_R:   w_byte = {r_dev, 1'b1};
            S_REG_HI:  w_byte = r_addr[15:8];
            S_REG_LO:  w_byte = r_addr[7:0];
            S_DATA_WR: w_byte = r_data;
            default:   w_byte = 8'h00;
        endcase
    end

    // Line levels for the quarter about to begin; SDA in byte states moves only at q0.
    always_comb begin
        w_scl = 1'b0;
        w_sda = r_sda_oe;
        case (w_nstate)
            S_START: begin
                w_scl = (w_nphase == 2'd3);
                w_sda = w_nphase[1];
            end
            S_RSTART: begin
                w_scl = (w_nphase == 2'd0) || (w_nphase == 2'd3);
                w_sda = w_nphase[1];
            end
            S_STOP: begin
                w_scl = (w_nphase == 2'd0);
                w_sda = (w_nphase != 2'd3);
            end
            S_DEV_W, S_REG_HI, S_REG_LO, S_DATA_WR, S_DEV_R: begin
                w_scl = (w_nphase == 2'd0) || (w_nphase == 2'd3);
                if (w_nphase == 2'd0)
                    w_sda = (w_nbit < 4'd8) ? ~w_byte[3'(4'd7 - w_nbit)] : 1'b0;
            end
            S_DATA_RD: begin
                w_scl = (w_nphase == 2'd0) || (w_nphase == 2'd3);
                w_sda = 1'b0;
            end
            default: w_sda = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_qcnt    <= '0;
            r_phase   <= 2'd0;
            r_bit     <= 4'd0;
            r_addr    <= 16'h0000;
            r_data    <= 8'h00;
            r_dev     <= 7'h00;
            r_wr      <= 1'b0;
            r_err     <= 1'b0;
            r_rx      <= 8'h00;
            r_scl_oe  <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_awready <= 1'b0;
            r_arready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_rresp   <= 2'b00;
            r_rdata   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_qcnt  <= '0;
                    r_phase <= 2'd0;
                    r_bit   <= 4'd0;
                    if (r_awready) begin
                        r_awready <= 1'b0;
                        r_addr    <= axil_i.awaddr;
                        r_data    <= axil_i.wdata;
                        r_dev     <= slave_addr_i;
                        r_wr      <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_START;
                    end else if (r_arready) begin
                        r_arready <= 1'b0;
                        r_addr    <= axil_i.araddr;
                        r_dev     <= slave_addr_i;
                        r_wr      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_START;
                    end else if (w_wr_req) begin
                        r_awready <= 1'b1;
                    end else if (w_rd_req) begin
                        r_arready <= 1'b1;
                    end
                end
                // Ready is raised in the handshake cycle so the next accept lands right after it.
                S_RESP: begin
                    if (w_resp_done) begin
                        r_bvalid <= 1'b0;
                        r_rvalid <= 1'b0;
                        r_err    <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                        if (w_wr_req)
                            r_awready <= 1'b1;
                        else if (w_rd_req)
                            r_arready <= 1'b1;
                    end
                end
                default: begin
                    r_qcnt <= w_qend ? '0 : r_qcnt + QW'(1);
                    if (w_qend) begin
                        r_phase  <= w_nphase;
                        r_scl_oe <= w_scl;
                        r_sda_oe <= w_sda;
                        r_state  <= w_nstate;
                        r_bit    <= w_nbit;
                    end
                    if (w_qend && r_phase == 2'd1) begin
                        if (w_tx_state && r_bit == 4'd8 && sda_i)
                            r_err <= 1'b1;
                        if (r_state == S_DATA_RD && r_bit != 4'd8)
                            r_rx <= {r_rx[6:0], sda_i};
                    end
                    if (w_bend && r_state == S_TBUF) begin
                        if (r_wr) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= r_err ? 2'b10 : 2'b00;
                        end else begin
                            r_rvalid <= 1'b1;
                            r_rresp  <= r_err ? 2'b10 : 2'b00;
                            r_rdata  <= r_err ? 8'h00 : r_rx;
                        end
                    end
                end
            endcase
        end
    end

    assign scl_oe_o       = r_scl_oe;
    assign sda_oe_o       = r_sda_oe;
    assign busy_o         = r_busy;
    assign axil_i.awready = r_awready;
    assign axil_i.wready  = r_awready;
    assign axil_i.arready = r_arready;
    assign axil_i.bvalid  = r_bvalid;
    assign axil_i.bresp   = r_bresp;
    assign axil_i.rvalid  = r_rvalid;
    assign axil_i.rresp   = r_rresp;
    assign axil_i.rdata   = r_rdata;
endmodule
